// File: rtl/systol_mm_param_if.sv
// Load/drain handshake bundle for the parametrised systolic matrix multiplier.
// The feeder/consumer side uses master, the array itself uses slave.
interface systol_mm_param_if #(
    parameter int N  = 3,
    parameter int DW = 5,
    parameter int AW = 30
);
    localparam int RW = (N > 1) ? $clog2(N) : 1;

    logic            start;
    logic            acc_en;
    logic            in_valid;
    logic            in_ready;
    logic [N*DW-1:0] a_col;
    logic [N*DW-1:0] b_row;
    logic            out_valid;
    logic            out_ready;
    logic [N*AW-1:0] c_row;
    logic [RW-1:0]   out_row_idx;
    logic            busy;
    logic            done;

    modport master (
        output start, acc_en, in_valid, a_col, b_row, out_ready,
        input  in_ready, out_valid, c_row, out_row_idx, busy, done
    );

    modport slave (
        input  start, acc_en, in_valid, a_col, b_row, out_ready,
        output in_ready, out_valid, c_row, out_row_idx, busy, done
    );
endinterface

// File: rtl/systol_mm_param.sv
// N x N output-stationary systolic matrix multiplier with internal operand
// skewing, valid/ready load and drain, signed/unsigned and accumulate modes.
module systol_mm_param #(
    parameter int N      = 3,
    parameter int DW     = 5,
    parameter int AW     = 30,
    parameter int SIGNED = 0
) (
    input logic              clk,
    input logic              rst,
    systol_mm_param_if.slave bus
);
    localparam int RW  = (N > 1) ? $clog2(N) : 1;
    localparam int CW  = $clog2(2 * N);
    localparam int SKW = (N * (N - 1)) / 2;
    localparam logic [CW-1:0] LAST_BEAT  = CW'(N - 1);
    localparam logic [CW-1:0] FLUSH_LAST = CW'(2 * N - 2);
    localparam logic [RW-1:0] LAST_ROW   = RW'(N - 1);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic [CW-1:0]   r_beatCnt;
    logic [CW-1:0]   r_flushCnt;
    logic [RW-1:0]   r_rowIdx;
    logic            r_done;
    logic [N*AW-1:0] r_cHold;
    logic [N*AW-1:0] w_cSel;
    logic            w_accept;
    logic            w_rowAccept;
    logic            w_clearAcc;

    logic [DW-1:0]   w_aBeat [N];
    logic [DW-1:0]   w_bBeat [N];
    logic [SKW*DW-1:0] r_aSkew;
    logic [SKW*DW-1:0] r_bSkew;
    logic [DW-1:0]   w_aIn   [N][N];
    logic [DW-1:0]   w_bIn   [N][N];
    logic [DW-1:0]   r_aFwd  [N][N-1];
    logic [DW-1:0]   r_bFwd  [N-1][N];
    logic [AW-1:0]   r_acc   [N][N];

    // Skew chain for lane i occupies stages skewBase(i) .. skewBase(i)+i-1.
    function automatic int skewBase(input int i);
        return (i * (i - 1)) / 2;
    endfunction

    function automatic logic [AW-1:0] mulExt(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic signed [2*DW-1:0] sa;
        logic signed [2*DW-1:0] sb;
        logic signed [2*DW-1:0] ps;
        logic [2*DW-1:0]        pu;
        sa = (2*DW)'($signed(a));
        sb = (2*DW)'($signed(b));
        ps = sa * sb;
        pu = (2*DW)'(a) * (2*DW)'(b);
        if (SIGNED != 0)
            return AW'(ps);
        else
            return AW'(pu);
    endfunction

    assign w_accept    = (r_state == LOAD) && bus.in_valid;
    assign w_rowAccept = (r_state == DRAIN) && bus.out_ready;
    assign w_clearAcc  = (r_state == IDLE) && bus.start && !bus.acc_en;

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_nextState = LOAD;
            LOAD:    if (w_accept && (r_beatCnt == LAST_BEAT)) w_nextState = FLUSH;
            FLUSH:   if (r_flushCnt == FLUSH_LAST) w_nextState = DRAIN;
            DRAIN:   if (w_rowAccept && (r_rowIdx == LAST_ROW)) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // The flush counter is zero on the edge that accepts the last beat, so the
    // DRAIN entry lands 2N-1 edges later, after the corner PE's last product.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_beatCnt  <= '0;
            r_flushCnt <= '0;
            r_rowIdx   <= '0;
            r_done     <= 1'b0;
            r_cHold    <= '0;
        end else begin
            r_done <= w_rowAccept && (r_rowIdx == LAST_ROW);
            if (r_state == IDLE)
                r_beatCnt <= '0;
            else if (w_accept)
                r_beatCnt <= r_beatCnt + 1'b1;
            if (r_state == FLUSH)
                r_flushCnt <= r_flushCnt + 1'b1;
            else
                r_flushCnt <= '0;
            if (w_rowAccept)
                r_rowIdx <= (r_rowIdx == LAST_ROW) ? '0 : r_rowIdx + 1'b1;
            if (r_state == DRAIN)
                r_cHold <= w_cSel;
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_aBeat[i] = w_accept ? bus.a_col[i*DW +: DW] : '0;
            w_bBeat[i] = w_accept ? bus.b_row[i*DW +: DW] : '0;
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                w_aIn[i][j] = '0;
                w_bIn[i][j] = '0;
            end
        w_aIn[0][0] = w_aBeat[0];
        w_bIn[0][0] = w_bBeat[0];
        for (int i = 1; i < N; i++)
            w_aIn[i][0] = r_aSkew[(skewBase(i) + i - 1)*DW +: DW];
        for (int j = 1; j < N; j++)
            w_bIn[0][j] = r_bSkew[(skewBase(j) + j - 1)*DW +: DW];
        for (int i = 0; i < N; i++)
            for (int j = 1; j < N; j++)
                w_aIn[i][j] = r_aFwd[i][j-1];
        for (int i = 1; i < N; i++)
            for (int j = 0; j < N; j++)
                w_bIn[i][j] = r_bFwd[i-1][j];
    end

    // Idle and gap cycles feed zeros, so the accumulators only move on real data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_aSkew <= '0;
            r_bSkew <= '0;
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N - 1; j++)
                    r_aFwd[i][j] <= '0;
            for (int i = 0; i < N - 1; i++)
                for (int j = 0; j < N; j++)
                    r_bFwd[i][j] <= '0;
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    r_acc[i][j] <= '0;
        end else begin
            for (int i = 1; i < N; i++) begin
                r_aSkew[skewBase(i)*DW +: DW] <= w_aBeat[i];
                r_bSkew[skewBase(i)*DW +: DW] <= w_bBeat[i];
                for (int s = 1; s < i; s++) begin
                    r_aSkew[(skewBase(i) + s)*DW +: DW] <= r_aSkew[(skewBase(i) + s - 1)*DW +: DW];
                    r_bSkew[(skewBase(i) + s)*DW +: DW] <= r_bSkew[(skewBase(i) + s - 1)*DW +: DW];
                end
            end
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N - 1; j++)
                    r_aFwd[i][j] <= w_aIn[i][j];
            for (int i = 0; i < N - 1; i++)
                for (int j = 0; j < N; j++)
                    r_bFwd[i][j] <= w_bIn[i][j];
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    r_acc[i][j] <= w_clearAcc ? '0 : r_acc[i][j] + mulExt(w_aIn[i][j], w_bIn[i][j]);
        end
    end

    always_comb begin
        w_cSel = '0;
        for (int r = 0; r < N; r++)
            if (r_rowIdx == RW'(r))
                for (int j = 0; j < N; j++)
                    w_cSel[j*AW +: AW] = r_acc[r][j];
    end

    assign bus.in_ready    = (r_state == LOAD);
    assign bus.out_valid   = (r_state == DRAIN);
    assign bus.busy        = (r_state != IDLE);
    assign bus.done        = r_done;
    assign bus.out_row_idx = r_rowIdx;
    assign bus.c_row       = (r_state == DRAIN) ? w_cSel : r_cHold;
endmodule

// File: tb/tb_systol_mm_param.sv
// Self-checking bench: an unsigned and a signed 3x3 array run in lockstep
// against a matrix-product model; a 5x5 signed array covers the wrap case.
module tb_systol_mm_param;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    systol_mm_param_if #(.N(3), .DW(5), .AW(30)) ifU ();
    systol_mm_param_if #(.N(3), .DW(5), .AW(10)) ifS ();
    systol_mm_param_if #(.N(5), .DW(5), .AW(10)) if5 ();

    assign ifS.start     = ifU.start;
    assign ifS.acc_en    = ifU.acc_en;
    assign ifS.in_valid  = ifU.in_valid;
    assign ifS.a_col     = ifU.a_col;
    assign ifS.b_row     = ifU.b_row;
    assign ifS.out_ready = ifU.out_ready;

    systol_mm_param #(.N(3), .DW(5), .AW(30), .SIGNED(0)) dutU (.clk(clk), .rst(rst), .bus(ifU));
    systol_mm_param #(.N(3), .DW(5), .AW(10), .SIGNED(1)) dutS (.clk(clk), .rst(rst), .bus(ifS));
    systol_mm_param #(.N(5), .DW(5), .AW(10), .SIGNED(1)) dut5 (.clk(clk), .rst(rst), .bus(if5));

    int     vectors = 0;
    int     miscompares = 0;
    int     A [3][3];
    int     B [3][3];
    longint mU [3][3];
    longint mS [3][3];
    int     doneCountU = 0;
    int     doneCount5 = 0;
    int     jobsDone = 0;

    always @(posedge clk) begin
        if (ifU.done) doneCountU <= doneCountU + 1;
        if (if5.done) doneCount5 <= doneCount5 + 1;
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint toSigned5(input int v);
        return (v >= 16) ? longint'(v - 32) : longint'(v);
    endfunction

    // C = A*B, optionally added to the previous C, reduced to each array's width.
    task automatic modelJob(input bit accEn);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                if (!accEn) begin
                    mU[i][j] = 0;
                    mS[i][j] = 0;
                end
                for (int k = 0; k < 3; k++) begin
                    mU[i][j] += longint'(A[i][k]) * longint'(B[k][j]);
                    mS[i][j] += toSigned5(A[i][k]) * toSigned5(B[k][j]);
                end
                mU[i][j] = mU[i][j] & ((64'd1 << 30) - 1);
                mS[i][j] = mS[i][j] & 64'd1023;
            end
    endtask

    task automatic setSeq(output int m [3][3]);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                m[i][j] = 3 * i + j + 1;
    endtask

    task automatic setIdentity();
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                B[i][j] = (i == j) ? 1 : 0;
    endtask

    task automatic startJob(input bit accEn);
        @(negedge clk);
        ifU.start  = 1'b1;
        ifU.acc_en = accEn;
        @(negedge clk);
        ifU.start  = 1'b0;
        ifU.acc_en = 1'b0;
        checkOutput("busy", ifU.busy, 1);
    endtask

    task automatic sendBeat(input int k);
        @(negedge clk);
        ifU.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ifU.a_col[i*5 +: 5] = 5'(A[i][k]);
            ifU.b_row[i*5 +: 5] = 5'(B[k][i]);
        end
        checkOutput("in_ready", ifU.in_ready, 1);
        @(posedge clk);
        #1;
        ifU.in_valid = 1'b0;
        ifU.a_col    = '0;
        ifU.b_row    = '0;
    endtask

    task automatic checkRow(input int r);
        checkOutput("out_valid", ifU.out_valid, 1);
        checkOutput("rowIdxU", ifU.out_row_idx, r);
        checkOutput("rowIdxS", ifS.out_row_idx, r);
        for (int j = 0; j < 3; j++) begin
            checkOutput($sformatf("cU[%0d][%0d]", r, j), ifU.c_row[j*30 +: 30], mU[r][j]);
            checkOutput($sformatf("cS[%0d][%0d]", r, j), ifS.c_row[j*10 +: 10], mS[r][j]);
        end
    endtask

    task automatic applyStimulus(input bit accEn, input int gap0, input int maxGap,
                                 input bit stall, input bit pokeStart);
        int lat;
        int g;
        startJob(accEn);
        modelJob(accEn);
        for (int k = 0; k < 3; k++) begin
            g = (k == 1) ? gap0 : 0;
            if (maxGap > 0) g += $urandom_range(0, maxGap);
            repeat (g) @(negedge clk);
            sendBeat(k);
        end
        lat = 0;
        while (!ifU.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("latency", lat, 5);
        for (int r = 0; r < 3; r++) begin
            if (stall && r == 1) begin
                repeat (4) begin
                    @(negedge clk);
                    if (pokeStart) ifU.start = 1'b1;
                    checkOutput("holdIdx", ifU.out_row_idx, 1);
                    for (int j = 0; j < 3; j++)
                        checkOutput("holdC", ifU.c_row[j*30 +: 30], mU[1][j]);
                end
                ifU.start = 1'b0;
            end
            @(negedge clk);
            ifU.out_ready = 1'b1;
            checkRow(r);
            @(posedge clk);
            #1;
            ifU.out_ready = 1'b0;
        end
        checkOutput("done", ifU.done, 1);
        checkOutput("idleBusy", ifU.busy, 0);
        checkOutput("idleValid", ifU.out_valid, 0);
        jobsDone++;
        @(posedge clk);
        #1;
        checkOutput("donePulse", ifU.done, 0);
        checkOutput("startIgnored", ifU.busy, 0);
    endtask

    // Every operand -16: signed products are +256, so N=5 sums to 1280 mod 1024.
    task automatic runWide();
        int lat;
        @(negedge clk);
        if5.start  = 1'b1;
        if5.acc_en = 1'b0;
        @(negedge clk);
        if5.start  = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if5.in_valid = 1'b1;
            if5.a_col    = {5{5'h10}};
            if5.b_row    = {5{5'h10}};
            @(posedge clk);
            #1;
            if5.in_valid = 1'b0;
        end
        lat = 0;
        while (!if5.out_valid && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("latency5", lat, 9);
        for (int r = 0; r < 5; r++) begin
            @(negedge clk);
            if5.out_ready = 1'b1;
            checkOutput("rowIdx5", if5.out_row_idx, r);
            for (int j = 0; j < 5; j++)
                checkOutput($sformatf("c5[%0d][%0d]", r, j), if5.c_row[j*10 +: 10], 256);
            @(posedge clk);
            #1;
            if5.out_ready = 1'b0;
        end
        checkOutput("done5", if5.done, 1);
    endtask

    initial begin
        rst           = 1'b1;
        ifU.start     = 1'b0;
        ifU.acc_en    = 1'b0;
        ifU.in_valid  = 1'b0;
        ifU.a_col     = '0;
        ifU.b_row     = '0;
        ifU.out_ready = 1'b0;
        if5.start     = 1'b0;
        if5.acc_en    = 1'b0;
        if5.in_valid  = 1'b0;
        if5.a_col     = '0;
        if5.b_row     = '0;
        if5.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstBusy", ifU.busy, 0);
        checkOutput("rstInReady", ifU.in_ready, 0);
        checkOutput("rstOutValid", ifU.out_valid, 0);
        checkOutput("rstDone", ifU.done, 0);
        checkOutput("rstCrowLo", ifU.c_row[63:0], 0);
        checkOutput("rstCrowHi", 64'(ifU.c_row[89:64]), 0);
        checkOutput("rstRowIdx", ifU.out_row_idx, 0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] identity");
        setSeq(A);
        setIdentity();
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0);

        $display("[TB] square with gaps");
        setSeq(A);
        setSeq(B);
        applyStimulus(1'b0, 2, 0, 1'b0, 1'b0);

        $display("[TB] accumulate");
        applyStimulus(1'b1, 2, 0, 1'b0, 1'b0);
        setIdentity();
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0);

        $display("[TB] signed wrap");
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                A[i][j] = 16;
                B[i][j] = 16;
            end
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0);
        runWide();

        $display("[TB] back-pressure");
        setSeq(A);
        setSeq(B);
        applyStimulus(1'b0, 0, 0, 1'b1, 1'b1);

        $display("[TB] reset mid-load");
        setSeq(A);
        setIdentity();
        startJob(1'b0);
        sendBeat(0);
        sendBeat(1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midRstBusy", ifU.busy, 0);
        checkOutput("midRstInReady", ifU.in_ready, 0);
        checkOutput("midRstDone", ifU.done, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                mU[i][j] = 0;
                mS[i][j] = 0;
            end
        applyStimulus(1'b1, 0, 0, 1'b0, 1'b0);

        $display("[TB] random jobs");
        repeat (8) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++) begin
                    A[i][j] = int'($urandom_range(0, 31));
                    B[i][j] = int'($urandom_range(0, 31));
                end
            applyStimulus(1'($urandom_range(0, 1)), 0, 2, 1'($urandom_range(0, 1)), 1'b0);
        end

        repeat (2) @(posedge clk);
        #1;
        checkOutput("doneCount", doneCountU, jobsDone);
        checkOutput("doneCount5", doneCount5, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
